// File: rtl/conn_aging_scheduler_if.sv
// Timestamp-table port, packet-path refresh and delete-queue signals of the aging scheduler.
// master = scheduler side, slave = table / packet path / connection manager side.
interface conn_aging_scheduler_if #(
  parameter int W_FLOWID = 16,
  parameter int D_TSTB   = 10,
  parameter int W_TS     = 32
);
  logic                tsTb_busy;
  logic                upd_valid;
  logic [W_FLOWID-1:0] upd_flowID;
  logic [D_TSTB-1:0]   idx_tsTb;
  logic                rdValid_tsTb;
  logic                wrValid_tsTb;
  logic [W_TS:0]       data_tsTb;
  logic [W_TS:0]       ctx_tsTb;
  logic                del_ready;
  logic                del_conn_valid;
  logic [W_FLOWID-1:0] del_conn_info;

  modport master (
    input  tsTb_busy, upd_valid, upd_flowID, ctx_tsTb, del_ready,
    output idx_tsTb, rdValid_tsTb, wrValid_tsTb, data_tsTb, del_conn_valid, del_conn_info
  );

  modport slave (
    output tsTb_busy, upd_valid, upd_flowID, ctx_tsTb, del_ready,
    input  idx_tsTb, rdValid_tsTb, wrValid_tsTb, data_tsTb, del_conn_valid, del_conn_info
  );
endinterface

// File: rtl/conn_aging_scheduler.sv
// Sweeps flowIDs 1..MAX_FLOWID of the timestamp table and retires idle entries via delete requests.
// Optional saturating aged-flow counter built only when AGING_STAT_EN is defined.
module conn_aging_scheduler #(
  parameter int                  W_FLOWID      = 16,
  parameter int                  D_TSTB        = 10,
  parameter int                  W_TS          = 32,
  parameter logic [W_FLOWID-1:0] MAX_FLOWID    = 16'h3fe,
  parameter logic [W_TS-1:0]     AGE_THRESHOLD = 32'd1000000,
  parameter logic [15:0]         SCAN_GAP      = 16'd1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [W_TS-1:0]               cur_time,
  conn_aging_scheduler_if.master        tbl,
  output logic [31:0]                   aged_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GAP        = 3'd1,
    ISSUE_RD   = 3'd2,
    WAIT_RAM_1 = 3'd3,
    WAIT_RAM_2 = 3'd4,
    CHECK      = 3'd5,
    EMIT       = 3'd6,
    NEXT       = 3'd7
  } state_t;

  localparam logic [W_FLOWID-1:0] FIRST_ID = {{(W_FLOWID-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [W_FLOWID-1:0] cur_id_r, cur_id_s;
  logic                abort_r, abort_s;
  logic [W_TS:0]       ctx_r, ctx_s;
  logic [15:0]         gap_cnt_r, gap_cnt_s;
  logic                rd_s, wr_s, del_s;
  logic                upd_hit_s;
  logic [W_TS-1:0]     age_diff_s;
  logic                aged_s;

  assign upd_hit_s  = tbl.upd_valid && (tbl.upd_flowID == cur_id_r);
  // Unsigned modular difference keeps the age test correct across time-base wrap.
  assign age_diff_s = cur_time - ctx_r[W_TS-1:0];
  assign aged_s     = ctx_r[W_TS] && (age_diff_s >= AGE_THRESHOLD);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cur_id_r  <= FIRST_ID;
      abort_r   <= 1'b0;
      ctx_r     <= {(W_TS+1){1'b0}};
      gap_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_s;
      cur_id_r  <= cur_id_s;
      abort_r   <= abort_s;
      ctx_r     <= ctx_s;
      gap_cnt_r <= gap_cnt_s;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_s   = state_r;
    cur_id_s  = cur_id_r;
    abort_s   = abort_r;
    ctx_s     = ctx_r;
    gap_cnt_s = gap_cnt_r;
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    del_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cur_id_s = FIRST_ID;
        abort_s  = 1'b0;
        if (enable) begin
          state_s = ISSUE_RD;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE_RD: begin
        if (!tbl.tsTb_busy) begin
          rd_s    = 1'b1;
          abort_s = upd_hit_s;
          state_s = WAIT_RAM_1;
        end else begin
          abort_s = abort_r | upd_hit_s;
        end
      end
      WAIT_RAM_1: begin
        abort_s = abort_r | upd_hit_s;
        state_s = WAIT_RAM_2;
      end
      WAIT_RAM_2: begin
        abort_s = abort_r | upd_hit_s;
        ctx_s   = tbl.ctx_tsTb;
        state_s = CHECK;
      end
      CHECK: begin
        abort_s = abort_r | upd_hit_s;
        if (aged_s && !abort_r) begin
          state_s = EMIT;
        end else begin
          state_s = NEXT;
        end
      end
      EMIT: begin
        // A refresh arriving in the would-be write cycle wins over the delete.
        if (abort_r || upd_hit_s) begin
          abort_s = 1'b1;
          state_s = NEXT;
        end else if (tbl.del_ready && !tbl.tsTb_busy) begin
          wr_s    = 1'b1;
          del_s   = 1'b1;
          state_s = NEXT;
        end else begin
          state_s = EMIT;
        end
      end
      NEXT: begin
        abort_s = 1'b0;
        if (cur_id_r == MAX_FLOWID) begin
          gap_cnt_s = 16'd0;
          state_s   = GAP;
        end else begin
          cur_id_s = cur_id_r + FIRST_ID;
          if (enable) begin
            state_s = ISSUE_RD;
          end else begin
            state_s = IDLE;
          end
        end
      end
      GAP: begin
        abort_s = 1'b0;
        if (gap_cnt_r == (SCAN_GAP - 16'd1)) begin
          state_s = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Strobes stay combinational on tsTb_busy so the port is never driven while the packet path owns it.
  assign tbl.rdValid_tsTb   = rd_s;
  assign tbl.wrValid_tsTb   = wr_s;
  assign tbl.idx_tsTb       = (rd_s || wr_s) ? cur_id_r[D_TSTB-1:0] : {D_TSTB{1'b0}};
  assign tbl.data_tsTb      = {(W_TS+1){1'b0}};
  assign tbl.del_conn_valid = del_s;
  assign tbl.del_conn_info  = del_s ? cur_id_r : {W_FLOWID{1'b0}};

`ifdef AGING_STAT_EN
  logic [31:0] aged_cnt_r;

  // Saturating count of delete pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aged_cnt_r <= 32'd0;
    end else if (del_s && (aged_cnt_r != 32'hffff_ffff)) begin
      aged_cnt_r <= aged_cnt_r + 32'd1;
    end else begin
      aged_cnt_r <= aged_cnt_r;
    end
  end

  assign aged_cnt = aged_cnt_r;
`else
  assign aged_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_conn_aging_scheduler.sv
// Directed bench for conn_aging_scheduler: 2-cycle-latency table model, event monitor, hand-computed checks.
module tb_conn_aging_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] cur_time;
  logic [31:0] aged_cnt;

  conn_aging_scheduler_if bus ();

  conn_aging_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .cur_time (cur_time),
    .tbl      (bus.master),
    .aged_cnt (aged_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // table model and bench-side loader
  logic [32:0] mem [0:1023];
  logic [32:0] s1;
  logic        clr    = 1'b1;
  logic        ld_en  = 1'b0;
  logic [9:0]  ld_idx = 10'd0;
  logic [32:0] ld_val = 33'd0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 33'd0;
      s1 <= 33'd0;
    end else if (ld_en) begin
      mem[ld_idx] <= ld_val;
    end else if (bus.wrValid_tsTb) begin
      mem[bus.idx_tsTb] <= bus.data_tsTb;
    end
    if (bus.rdValid_tsTb) s1 <= mem[bus.idx_tsTb];
    bus.ctx_tsTb <= s1;
  end

  // event monitor, sampled mid-cycle
  int          cyc       = 0;
  logic [9:0]  want_idx  = 10'h3ff;
  int          hit_cnt   = 0;
  int          hit_cyc   = 0;
  int          viol      = 0;
  int          wr_cnt    = 0;
  int          pulses    = 0;
  int          pulse_cyc = 0;
  int          pair_err  = 0;
  logic        prev_pulse = 1'b0;
  logic [9:0]  last_wr_idx  = 10'd0;
  logic [32:0] last_wr_data = 33'd0;
  logic [15:0] last_info    = 16'd0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.rdValid_tsTb && bus.idx_tsTb == want_idx) begin
      hit_cnt <= hit_cnt + 1;
      hit_cyc <= cyc;
    end
    if ((bus.rdValid_tsTb || bus.wrValid_tsTb) && bus.tsTb_busy) viol <= viol + 1;
    if (bus.wrValid_tsTb) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_idx  <= bus.idx_tsTb;
      last_wr_data <= bus.data_tsTb;
    end
    if (bus.del_conn_valid) begin
      pulses    <= pulses + 1;
      last_info <= bus.del_conn_info;
      pulse_cyc <= cyc;
    end
    if ((bus.del_conn_valid && (!bus.wrValid_tsTb || bus.idx_tsTb != bus.del_conn_info[9:0] || prev_pulse))
        || (!bus.del_conn_valid && bus.wrValid_tsTb))
      pair_err <= pair_err + 1;
    prev_pulse <= bus.del_conn_valid;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (12) step();
  endtask

  task automatic set_mem(input logic [9:0] i, input logic [32:0] v);
    ld_idx = i;
    ld_val = v;
    ld_en  = 1'b1;
    step();
    ld_en  = 1'b0;
  endtask

  // returns at the start of the cycle after the read of id
  task automatic wait_rd(input logic [9:0] id, input int budget, output int c);
    int   h0;
    logic got;
    want_idx = id;
    h0  = hit_cnt;
    got = 1'b0;
    c   = -1;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (hit_cnt != h0) begin
        got = 1'b1;
        c   = hit_cyc;
      end
    end
    chk("wait_rd", 64'(got), 64'd1);
  endtask

  int c, c0, r, s, m, s2;

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    cur_time = 32'd0;
    bus.tsTb_busy = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_flowID = 16'd0;
    bus.del_ready = 1'b1;
    step();
    step();
    clr = 1'b0;
    chk("rst_rd",   64'(bus.rdValid_tsTb),   64'd0);
    chk("rst_wr",   64'(bus.wrValid_tsTb),   64'd0);
    chk("rst_idx",  64'(bus.idx_tsTb),       64'd0);
    chk("rst_data", 64'(bus.data_tsTb),      64'd0);
    chk("rst_del",  64'(bus.del_conn_valid), 64'd0);
    chk("rst_info", 64'(bus.del_conn_info),  64'd0);
    chk("rst_cnt",  64'(aged_cnt),           64'd0);
    reset = 1'b1;
    step();

    // single aged flow 5
    set_mem(10'd5, {1'b1, 32'd100});
    cur_time = 32'd1000200;
    enable = 1'b1;
    wait_rd(10'd6, 60, c);
    enable = 1'b0;
    settle();
    chk("t1_pulses", 64'(pulses),       64'd1);
    chk("t1_info",   64'(last_info),    64'd5);
    chk("t1_wridx",  64'(last_wr_idx),  64'd5);
    chk("t1_wrdata", 64'(last_wr_data), 64'd0);
    chk("t1_mem5",   64'(mem[5]),       64'd0);

    // wrap-around: aged
    set_mem(10'd3, {1'b1, 32'hFFFFFF00});
    cur_time = 32'h000F4200;
    enable = 1'b1;
    wait_rd(10'd4, 60, c);
    enable = 1'b0;
    settle();
    chk("t2_pulses", 64'(pulses),    64'd2);
    chk("t2_info",   64'(last_info), 64'd3);
    chk("t2_mem3",   64'(mem[3]),    64'd0);

    // wrap-around: not aged
    set_mem(10'd3, {1'b1, 32'hFFFFFF00});
    cur_time = 32'h00000100;
    enable = 1'b1;
    wait_rd(10'd4, 60, c);
    enable = 1'b0;
    settle();
    chk("t2b_pulses", 64'(pulses), 64'd2);
    chk("t2b_mem3",   64'(mem[3]), 64'h1_FFFF_FF00);
    set_mem(10'd3, 33'd0);

    // threshold boundary: one below, then exactly at
    set_mem(10'd2, {1'b1, 32'd0});
    cur_time = 32'd999999;
    enable = 1'b1;
    wait_rd(10'd3, 60, c);
    enable = 1'b0;
    settle();
    chk("thr_below", 64'(pulses), 64'd2);
    cur_time = 32'd1000000;
    enable = 1'b1;
    wait_rd(10'd3, 60, c);
    enable = 1'b0;
    settle();
    chk("thr_at_pulses", 64'(pulses),    64'd3);
    chk("thr_at_info",   64'(last_info), 64'd2);
    chk("thr_at_mem2",   64'(mem[2]),    64'd0);

    // backpressure: 10 cycles of del_ready=0 in EMIT
    set_mem(10'd5, {1'b1, 32'd100});
    cur_time = 32'd1000200;
    bus.del_ready = 1'b0;
    enable = 1'b1;
    wait_rd(10'd5, 60, c);
    enable = 1'b0;
    repeat (13) step();
    chk("bp_nopulse", 64'(pulses), 64'd3);
    chk("bp_nowrite", 64'(wr_cnt), 64'd3);
    r = cyc;
    bus.del_ready = 1'b1;
    step();
    chk("bp_pulse_cyc", 64'(pulse_cyc), 64'(r));
    chk("bp_pulses",    64'(pulses),    64'd4);
    chk("bp_info",      64'(last_info), 64'd5);
    settle();

    // abort during WAIT_RAM_2, scan continues at 6
    set_mem(10'd5, {1'b1, 32'd100});
    enable = 1'b1;
    wait_rd(10'd5, 60, c);
    step();
    bus.upd_valid = 1'b1;
    bus.upd_flowID = 16'd5;
    step();
    bus.upd_valid = 1'b0;
    wait_rd(10'd6, 20, c);
    enable = 1'b0;
    settle();
    chk("ab_pulses", 64'(pulses), 64'd4);
    chk("ab_writes", 64'(wr_cnt), 64'd4);
    chk("ab_mem5",   64'(mem[5]), 64'h1_0000_0064);

    // refresh in the same cycle the delete would go out
    bus.del_ready = 1'b0;
    enable = 1'b1;
    wait_rd(10'd5, 60, c);
    enable = 1'b0;
    repeat (5) step();
    bus.del_ready = 1'b1;
    bus.upd_valid = 1'b1;
    bus.upd_flowID = 16'd5;
    step();
    bus.upd_valid = 1'b0;
    settle();
    chk("abs_pulses", 64'(pulses), 64'd4);
    chk("abs_writes", 64'(wr_cnt), 64'd4);
    chk("abs_mem5",   64'(mem[5]), 64'h1_0000_0064);

    // busy held 3 cycles at ISSUE_RD
    enable = 1'b1;
    step();
    bus.tsTb_busy = 1'b1;
    c0 = cyc;
    repeat (3) step();
    bus.tsTb_busy = 1'b0;
    wait_rd(10'd1, 10, c);
    enable = 1'b0;
    chk("busy_rd_cyc", 64'(c), 64'(c0 + 3));
    settle();

    // asynchronous reset while stalled in EMIT
    bus.del_ready = 1'b0;
    enable = 1'b1;
    wait_rd(10'd5, 60, c);
    enable = 1'b0;
    repeat (5) step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rd",   64'(bus.rdValid_tsTb),   64'd0);
    chk("arst_wr",   64'(bus.wrValid_tsTb),   64'd0);
    chk("arst_del",  64'(bus.del_conn_valid), 64'd0);
    chk("arst_info", 64'(bus.del_conn_info),  64'd0);
    chk("arst_cnt",  64'(aged_cnt),           64'd0);
    step();
    bus.del_ready = 1'b1;
    step();
    reset = 1'b1;
    settle();
    chk("arst_pulses", 64'(pulses), 64'd4);
    chk("arst_mem5",   64'(mem[5]), 64'h1_0000_0064);
    set_mem(10'd5, 33'd0);

    // full sweep with 3 aged flows, gap timing
    set_mem(10'd10,   {1'b1, 32'd100});
    set_mem(10'd500,  {1'b1, 32'd100});
    set_mem(10'd1021, {1'b1, 32'd100});
    enable = 1'b1;
    wait_rd(10'd1, 10, s);
    wait_rd(10'd1022, 7000, m);
    wait_rd(10'd1, 1100, s2);
    enable = 1'b0;
    settle();
    chk("sw_gap",    64'(s2 - m),    64'd1030);
    chk("sw_period", 64'(s2 - s),    64'd6138);
    chk("sw_pulses", 64'(pulses),    64'd7);
    chk("sw_info",   64'(last_info), 64'd1021);
    chk("sw_mem10",  64'(mem[10]),   64'd0);
    chk("sw_mem500", 64'(mem[500]),  64'd0);
    chk("sw_mem1021",64'(mem[1021]), 64'd0);
`ifdef AGING_STAT_EN
    chk("aged_cnt", 64'(aged_cnt), 64'd3);
`else
    chk("aged_cnt", 64'(aged_cnt), 64'd0);
`endif
    chk("busy_overlap", 64'(viol),     64'd0);
    chk("pulse_shape",  64'(pair_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
